// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared types and constants for the RTC access-port arbiter.
// Holds the FSM state enum, requester indices and index/one-hot helpers.
package rtc_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] REQ_IRQ  = 2'd0;
  localparam logic [1:0] REQ_SCAN = 2'd1;
  localparam logic [1:0] REQ_EDIT = 2'd2;

  localparam logic [7:0] DEFAULT_CMD_ADDR = 8'hF0;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rtc_bus_arbiter_rr_pick3.sv
// Combinational 3-way round-robin selector with an optional fixed-priority
// override for requester 0; produces a one-hot winner (zero when no request).
module rr_pick3
  import rtc_bus_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  input  logic       prio,
  output logic [2:0] win
);

  logic [1:0] first;
  logic [1:0] second;
  logic [1:0] third;

  // Search order starts just after the previous winner and wraps around.
  always_comb begin
    first  = next_idx(last);
    second = next_idx(first);
    third  = next_idx(second);
    win    = 3'b000;
    if (prio && req[REQ_IRQ]) begin
      win = idx_to_onehot(REQ_IRQ);
    end else if (|(req & idx_to_onehot(first))) begin
      win = idx_to_onehot(first);
    end else if (|(req & idx_to_onehot(second))) begin
      win = idx_to_onehot(second);
    end else if (|(req & idx_to_onehot(third))) begin
      win = idx_to_onehot(third);
    end
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Serialises alarm, menu-scan and user-edit accesses onto the single RTC
// bus-timing controller port, with locked bursts and FRW timeout abort.
module rtc_bus_arbiter
  import rtc_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT,
  parameter logic [7:0]  CMD_ADDR = DEFAULT_CMD_ADDR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  Req,
  input  logic [2:0]  Lock,
  input  logic [2:0]  Wr,
  input  logic [23:0] AddrIn,
  input  logic [23:0] WrData,
  output logic [2:0]  Gnt,
  output logic [2:0]  Done,
  output logic [7:0]  RdData,
  output logic        Err,
  output logic [7:0]  Dir,
  output logic        Mod,
  output logic [7:0]  DataOut,
  input  logic [7:0]  DataIn,
  output logic        Acceso,
  input  logic        FRW
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state;
  state_t     state_next;
  logic [1:0] winner;
  logic [1:0] last_winner;
  logic [2:0] win_oh;
  logic [2:0] pick;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic       err_pend;
  logic       cmd_write;
  logic       burst_ok;
  logic       timed_out;
  logic [7:0] addr_sel;
  logic [7:0] wdata_sel;

  rr_pick3 u_pick (
    .req  (Req),
    .last (last_winner),
    .prio (1'b1),
    .win  (pick)
  );

  assign win_oh    = idx_to_onehot(winner);
  assign cnt_inc   = cnt + 8'd1;
  assign timed_out = (cnt_inc == TIMEOUT_CNT);
  assign cmd_write = Mod && (Dir == CMD_ADDR);
  // A command write never chains, and an IRQ request breaks any other burst.
  assign burst_ok  = (|(Lock & Req & win_oh)) && !cmd_write &&
                     !(Req[REQ_IRQ] && (winner != REQ_IRQ));

  always_comb begin
    addr_sel  = AddrIn[23:16];
    wdata_sel = WrData[23:16];
    case (winner)
      2'd0: begin
        addr_sel  = AddrIn[7:0];
        wdata_sel = WrData[7:0];
      end
      2'd1: begin
        addr_sel  = AddrIn[15:8];
        wdata_sel = WrData[15:8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    Gnt        = 3'b000;
    Done       = 3'b000;
    Err        = 1'b0;
    Acceso     = 1'b0;
    case (state)
      IDLE: begin
        if (|Req) state_next = GRANT;
      end
      GRANT: begin
        Gnt        = win_oh;
        state_next = ACCESS;
      end
      ACCESS: begin
        Gnt    = win_oh;
        Acceso = 1'b1;
        if (FRW || timed_out) state_next = DONE;
      end
      DONE: begin
        Gnt        = win_oh;
        Done       = win_oh;
        Err        = err_pend;
        state_next = burst_ok ? GRANT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      winner      <= REQ_IRQ;
      last_winner <= REQ_EDIT;
      Dir         <= 8'h00;
      Mod         <= 1'b0;
      DataOut     <= 8'h00;
      RdData      <= 8'h00;
      cnt         <= 8'h00;
      err_pend    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|Req) winner <= onehot_to_idx(pick);
        end
        GRANT: begin
          Dir      <= addr_sel;
          DataOut  <= wdata_sel;
          Mod      <= |(Wr & win_oh);
          cnt      <= 8'h00;
          err_pend <= 1'b0;
        end
        ACCESS: begin
          if (cnt != TIMEOUT_CNT) cnt <= cnt_inc;
          if (FRW) begin
            if (!Mod) RdData <= DataIn;
          end else if (timed_out) begin
            err_pend <= 1'b1;
          end
        end
        DONE: begin
          if (!burst_ok) last_winner <= winner;
        end
        default: ;
      endcase
    end
  end

endmodule
